reg_serial_initiator: RTL
=========================

Name: reg_serial_initiator

Overview:
- Bit-serial command front-end that acts as the initiator on a 16-bit register's single read/write port pair.
- Receives an op bit and optional 16-bit payload over a one-bit serial link.
- Issues exactly one register operation per frame: a one-cycle write strobe or a one-cycle read strobe.
- Read results are shifted back out serially. Sits between an external debug/config pin pair and the register.

Parameters:
- DATA_W, 16, register data width and serial payload length in bits.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- ser_in  input  1  serial data bit, sampled only when ser_valid=1
- ser_valid  input  1  qualifies ser_in for one cycle
- frame_abort  input  1  synchronous abort; returns FSM to IDLE
- busy  output  1  high while not in IDLE/CMD-collecting states (WRITE, READ, SHIFT)
- ser_out  output  1  read-data bit, MSB first
- ser_out_valid  output  1  qualifies ser_out
- done  output  1  one-cycle pulse on completion of a frame
- reg_write_enable  output  1  write strobe to register
- reg_write_data  output  DATA_W  write payload, valid when reg_write_enable=1
- reg_read_enable  output  1  read strobe to register
- reg_read_data  input  DATA_W  register read data, combinational from register, valid while reg_read_enable=1

Behaviour:
- Reset (async): state=IDLE; all outputs 0; shift register and counter 0.
- States: IDLE, DATA, WRITE, READ, SHIFT.
- IDLE:
  - ser_valid=1 samples the op bit.
  - ser_in=1 goes to DATA with counter=0.
  - ser_in=0 goes to READ.
- DATA:
  - Each ser_valid=1 shifts ser_in into the LSB of the data shift register (MSB arrives first) and increments the counter.
  - Cycles with ser_valid=0 hold state.
  - On the DATA_W-th bit, go to WRITE.
- WRITE (exactly 1 cycle):
  - reg_write_enable=1, reg_write_data=assembled word, done=1, busy=1.
  - Next state IDLE.
  - reg_write_data is 0 whenever reg_write_enable=0.
- READ (exactly 1 cycle):
  - reg_read_enable=1, busy=1.
  - reg_read_data is captured into the shift register at the end of this cycle.
  - Next state SHIFT with counter=0.
- SHIFT (exactly DATA_W cycles):
  - ser_out_valid=1; ser_out=captured MSB first.
  - done=1 on the last bit cycle only; next state IDLE.
- Mutual exclusion: reg_read_enable and reg_write_enable are never high in the same cycle; an assertion must be provided.
- Latencies:
  - Write strobe occurs the cycle after the 16th payload bit is sampled.
  - Read strobe occurs the cycle after the op bit is sampled.
  - First ser_out bit appears 2 cycles after the op bit is sampled.
- ser_valid during WRITE, READ or SHIFT is ignored; those bits are dropped, not queued.
- frame_abort=1 in any state:
  - Next state IDLE; counter cleared.
  - No strobe is issued in the following cycle; done is not pulsed.
  - If abort coincides with WRITE/READ, that cycle's strobe still asserts, because outputs are state-decoded.
- frame_abort has priority over ser_valid in IDLE.
- Async reset mid-frame immediately drops all strobes and ser_out_valid.
- The counter saturates by design via the state exit; no wrap beyond DATA_W.

Decomposition:
- Shared package reg_if_pkg holds the state enum (IDLE, DATA, WRITE, READ, SHIFT), OP_WRITE=1'b1, OP_READ=1'b0, and default DATA_W.
- One natural sub-module, serdes_shift: a DATA_W-bit shift register with parallel load, serial in and serial out, used for both assembly and readout.

Test Plan:
- Write frame: op=1 then payload 0xA5C3 MSB first, back-to-back -> exactly one cycle with reg_write_enable=1, reg_write_data=0xA5C3, done=1, one cycle after the last bit.
- Read frame with reg_read_data=0x1234: op=0 -> reg_read_enable high for 1 cycle; then 16 cycles of ser_out_valid with ser_out stream 0001_0010_0011_0100; done on the 16th cycle.
- Gapped write: payload 0xFFFF with ser_valid=0 gaps of 1-3 cycles between bits -> identical single write of 0xFFFF; no strobe while waiting.
- Abort after 8 payload bits of a write -> no reg_write_enable, no done; a subsequent full write of 0x0001 is written correctly.
- ser_valid pulses during SHIFT of a read returning 0xBEEF -> readout is unchanged 0xBEEF; the ignored bits do not start a new frame.
- Async reset asserted mid-SHIFT -> ser_out_valid, busy and done go 0 immediately; the next op bit is accepted from IDLE.

Source files
------------

// File: rtl/reg_if_pkg.sv
// Shared definitions for the bit-serial register initiator.
// Holds the FSM state encoding, the op-bit encodings carried in the first
// bit of every frame, and the default register/payload width.
package reg_if_pkg;

  localparam int DATA_W_DEFAULT = 16;

  // First serial bit of a frame selects the operation.
  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WRITE,
    READ,
    SHIFT
  } state_t;

endpackage

// File: rtl/reg_serial_initiator_serdes_shift.sv
// serdes_shift: DATA_W-bit shift register with parallel load, serial in at
// the LSB and serial out from the MSB. It assembles incoming write payloads
// and serialises captured read data.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   load        - parallel load of load_data (takes priority over shift)
//   load_data   - parallel word to capture
//   shift       - shift left by one, shift_in entering at the LSB
//   shift_in    - serial input bit
//   data        - current register contents
//   msb         - serial output (data MSB)
module serdes_shift #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              shift_in,
  output logic [DATA_W-1:0] data,
  output logic              msb
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {data[DATA_W-2:0], shift_in};
    end
  end

  assign msb = data[DATA_W-1];

endmodule

// File: rtl/reg_serial_initiator.sv
// reg_serial_initiator: bit-serial command front-end that drives one
// register's read/write port pair. A frame is an op bit followed, for writes,
// by a DATA_W-bit payload MSB first. Each frame issues exactly one one-cycle
// register strobe; read results are shifted back out MSB first.
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   ser_in, ser_valid - serial command/payload bit and its qualifier
//   frame_abort       - synchronous abort back to IDLE
//   busy              - high in WRITE, READ and SHIFT
//   ser_out, ser_out_valid - serial read data and its qualifier
//   done              - one-cycle pulse on frame completion
//   reg_write_enable, reg_write_data - register write strobe and payload
//   reg_read_enable, reg_read_data   - register read strobe and read data
// CNT_W must satisfy 2**CNT_W > DATA_W.
module reg_serial_initiator
  import reg_if_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              frame_abort,
  output logic              busy,
  output logic              ser_out,
  output logic              ser_out_valid,
  output logic              done,
  output logic              reg_write_enable,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              reg_read_enable,
  input  logic [DATA_W-1:0] reg_read_data
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              sr_load;
  logic              sr_shift;
  logic              sr_shift_in;
  logic [DATA_W-1:0] sr_data;
  logic              sr_msb;

  serdes_shift #(
    .DATA_W(DATA_W)
  ) u_serdes (
    .clk       (clk),
    .reset     (reset),
    .load      (sr_load),
    .load_data (reg_read_data),
    .shift     (sr_shift),
    .shift_in  (sr_shift_in),
    .data      (sr_data),
    .msb       (sr_msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Outputs are decoded from the current state only, so a strobe in WRITE or
  // READ still fires in the cycle an abort arrives; the abort only redirects
  // the next state and suppresses shift-register updates.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    sr_load          = 1'b0;
    sr_shift         = 1'b0;
    sr_shift_in      = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    ser_out          = 1'b0;
    ser_out_valid    = 1'b0;
    reg_write_enable = 1'b0;
    reg_write_data   = '0;
    reg_read_enable  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ser_valid) begin
          if (ser_in == OP_WRITE) begin
            state_d = DATA;
            count_d = '0;
          end else begin
            state_d = READ;
          end
        end
      end

      DATA: begin
        if (ser_valid) begin
          sr_shift    = 1'b1;
          sr_shift_in = ser_in;
          if (count_q == LAST_BIT) begin
            state_d = WRITE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      WRITE: begin
        busy             = 1'b1;
        done             = 1'b1;
        reg_write_enable = 1'b1;
        reg_write_data   = sr_data;
        state_d          = IDLE;
      end

      READ: begin
        busy            = 1'b1;
        reg_read_enable = 1'b1;
        sr_load         = 1'b1;
        state_d         = SHIFT;
        count_d         = '0;
      end

      SHIFT: begin
        busy          = 1'b1;
        ser_out_valid = 1'b1;
        ser_out       = sr_msb;
        sr_shift      = 1'b1;
        if (count_q == LAST_BIT) begin
          done    = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    if (frame_abort) begin
      state_d  = IDLE;
      count_d  = '0;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
    end
  end

  a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(reg_read_enable && reg_write_enable));

endmodule
